// File: rtl/logic_tt_recorder.sv
// logic_tt_recorder: sweeps all N_IN-bit input combinations on stim and records F into a truth table.
//   clk, rst (async, active-high), start (begin sweep, IDLE only), mode (internal function, latched),
//   src_sel (0 internal F, 1 ext_f, latched), ext_f (external circuit output),
//   stim (current combination), busy (sweeping), done (end-of-sweep pulse),
//   tt (bit i = F(stim=i)), pass / mismatch_cnt (golden compare, only with macro TT_CHECK_EN).
module logic_tt_recorder #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1,
    parameter int TT_W   = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              src_sel,
    input  logic              ext_f,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic              pass,
    output logic [N_IN:0]     mismatch_cnt
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [1:0] mode_l;
    logic src_l, a, r, p, f_int, f_sel, last_cyc, last_vec, wr;
    always_comb begin
        a        = stim[N_IN-1];
        r        = |stim[N_IN-2:0];
        p        = &stim[N_IN-2:0];
        f_int    = mode_l == 2'd0 ? (a & r) :
                   mode_l == 2'd1 ? (a | p) :
                   mode_l == 2'd2 ? (a ^ r) : ~(a & r);
        f_sel    = src_l ? ext_f : f_int;
        last_cyc = cnt == 4'(SETTLE);
        last_vec = stim == N_IN'(TT_W - 1);
        wr       = state == APPLY && last_cyc;
        state_nx = state == IDLE  ? (start ? APPLY : IDLE) :
                   state == APPLY ? (last_cyc && last_vec ? DONE : APPLY) : IDLE;
        busy     = state == APPLY;
        done     = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            stim   <= '0;
            cnt    <= '0;
            tt     <= '0;
            mode_l <= '0;
            src_l  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                stim   <= '0;
                cnt    <= '0;
                tt     <= '0;
                mode_l <= mode;
                src_l  <= src_sel;
            end else if (wr) begin
                tt[stim] <= f_sel;
                cnt      <= '0;
                if (!last_vec) stim <= stim + 1'b1;
            end else if (state == APPLY) begin
                cnt <= cnt + 4'd1;
            end else if (state == DONE) begin
                stim <= '0;
            end
        end
    end
`ifdef TT_CHECK_EN
    logic miss;
    assign miss = wr && (f_sel != f_int);
    // pass folds in the final sample's compare, which lands on the same edge as done rising
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= '0;
            pass         <= 1'b0;
        end else if (state == IDLE && start) begin
            mismatch_cnt <= '0;
            pass         <= 1'b0;
        end else begin
            if (miss) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (wr && last_vec) pass <= (mismatch_cnt == '0) && !miss;
        end
    end
`else
    assign pass         = 1'b0;
    assign mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_logic_tt_recorder.sv
// tb_logic_tt_recorder: scoreboard bench for logic_tt_recorder (N_IN=3/SETTLE=1 and N_IN=4/SETTLE=0).
module tb_logic_tt_recorder;
    logic clk = 1'b0, rst = 1'b1;
    logic start3 = 1'b0, src3 = 1'b0, ext3;
    logic [1:0] mode3 = 2'd0;
    logic [2:0] stim3;
    logic busy3, done3, pass3;
    logic [7:0] tt3;
    logic [3:0] mm3;
    logic start4 = 1'b0;
    logic [1:0] mode4 = 2'd0;
    logic [3:0] stim4;
    logic busy4, done4, pass4;
    logic [15:0] tt4;
    logic [4:0] mm4;
    int ext_mode = 0;
    int n_chk = 0, n_err = 0;
    logic [31:0] q_tt[$], q_pass[$], q_mm[$];

    always #5 clk = ~clk;

    // external gate-level circuit: correct A&(B|C), or stuck at 1
    assign ext3 = (ext_mode == 0) ? (stim3[2] & (stim3[1] | stim3[0])) : 1'b1;

    logic_tt_recorder #(.N_IN(3), .SETTLE(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .src_sel(src3), .ext_f(ext3),
        .stim(stim3), .busy(busy3), .done(done3), .tt(tt3), .pass(pass3), .mismatch_cnt(mm3));

    logic_tt_recorder #(.N_IN(4), .SETTLE(0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .src_sel(1'b0), .ext_f(1'b0),
        .stim(stim4), .busy(busy4), .done(done4), .tt(tt4), .pass(pass4), .mismatch_cnt(mm4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_model(input logic [1:0] m, input int v, input int n);
        int mask, low;
        logic a, r, p;
        mask = (1 << (n - 1)) - 1;
        low  = v & mask;
        a    = ((v >> (n - 1)) & 1) != 0;
        r    = low != 0;
        p    = low == mask;
        case (m)
            2'd0: return a && r;
            2'd1: return a || p;
            2'd2: return a != r;
            default: return !(a && r);
        endcase
    endfunction

    function automatic logic ext_model(input int em, input int v);
        return (em == 0) ? f_model(2'd0, v, 3) : 1'b1;
    endfunction

    task automatic run3(input logic [1:0] m, input logic s, input int em,
                        input int restart_at, input int abort_at);
        int cyc, bad;
        logic [31:0] et, ep, emm, junk;
        logic g, x;
        et = 0;
        emm = 0;
        for (int i = 0; i < 8; i++) begin
            g = f_model(m, i, 3);
            x = s ? ext_model(em, i) : g;
            et[i] = x;
            if (x != g) emm++;
        end
`ifdef TT_CHECK_EN
        ep = (emm == 0) ? 1 : 0;
`else
        ep = 0;
        emm = 0;
`endif
        q_tt.push_back(et);
        q_pass.push_back(ep);
        q_mm.push_back(emm);
        mode3 = m;
        src3 = s;
        ext_mode = em;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        chk("tt_cleared", tt3, 0);
        cyc = 0;
        bad = 0;
        while (busy3 && cyc < 100) begin
            if (stim3 != 3'(cyc / 2)) bad++;
            if (restart_at >= 0 && cyc == restart_at) start3 = 1'b1;
            if (restart_at >= 0 && cyc == restart_at + 1) begin
                start3 = 1'b0;
                mode3 = m ^ 2'd1;
            end
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", busy3, 0);
                chk("rst_done", done3, 0);
                chk("rst_stim", stim3, 0);
                chk("rst_tt", tt3, 0);
                chk("rst_pass", pass3, 0);
                chk("rst_mm", mm3, 0);
                junk = q_tt.pop_front();
                junk = q_pass.pop_front();
                junk = q_mm.pop_front();
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_len", cyc, 16);
        chk("stim_seq", bad, 0);
        chk("done_rise", done3, 1);
        et = q_tt.pop_front();
        ep = q_pass.pop_front();
        emm = q_mm.pop_front();
        chk("tt", tt3, et);
        chk("pass", pass3, ep);
        chk("mismatch_cnt", mm3, emm);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        chk("done_pulse", done3, 0);
        chk("no_start_in_done", busy3, 0);
        chk("stim_idle", stim3, 0);
        chk("tt_hold", tt3, et);
        chk("pass_hold", pass3, ep);
        @(posedge clk); #1;
        mode3 = 2'd0;
        src3 = 1'b0;
    endtask

    initial begin
        int cyc, bad;
        logic [15:0] et4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy3, 0);
        chk("reset_done", done3, 0);
        chk("reset_stim", stim3, 0);
        chk("reset_tt", tt3, 0);
        chk("reset_pass", pass3, 0);
        chk("reset_mm", mm3, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run3(2'd0, 1'b0, 0, -1, 0);
        run3(2'd1, 1'b0, 0, -1, 0);
        run3(2'd2, 1'b0, 0, -1, 0);
        run3(2'd3, 1'b0, 0, -1, 0);
        run3(2'd0, 1'b1, 0, -1, 0);
        run3(2'd0, 1'b1, 1, -1, 0);
        run3(2'd0, 1'b0, 0, 5, 0);
        run3(2'd2, 1'b0, 0, -1, 9);
        run3(2'd1, 1'b0, 0, -1, 0);
        // N_IN=4, SETTLE=0, mode1
        et4 = '0;
        for (int i = 0; i < 16; i++) et4[i] = f_model(2'd1, i, 4);
        chk("tt4_model", {16'd0, et4}, 32'hFF80);
        mode4 = 2'd1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        bad = 0;
        while (busy4 && cyc < 100) begin
            if (stim4 != 4'(cyc)) bad++;
`ifndef TT_CHECK_EN
            if (pass4 !== 1'b0 || mm4 !== 5'd0) bad++;
`endif
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy4_len", cyc, 16);
        chk("stim4_seq", bad, 0);
        chk("done4_rise", done4, 1);
        chk("tt4", tt4, et4);
`ifdef TT_CHECK_EN
        chk("pass4", pass4, 1);
`else
        chk("pass4", pass4, 0);
`endif
        chk("mm4", mm4, 0);
        @(posedge clk); #1;
        chk("done4_pulse", done4, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/logic_tt_recorder.md
Name: logic_tt_recorder

Overview:
Parametrised successor to the lab's single-function gate circuits (F = A(B+C) style). The block sweeps every N_IN-bit input combination, drives it on stim, and records each resulting F bit into a truth-table register. F is taken either from an internal mode-selectable function or from an external gate-level circuit-under-test driven by stim. Used as the lab's automatic truth-table recorder.

Parameters:
N_IN, 3, number of function inputs (2..6); stim[N_IN-1] is "A", the remaining bits are "B, C, ...".
SETTLE, 1, extra cycles stim is held before F is sampled (0..15).
TT_W, 2**N_IN, truth-table width (derived; do not override).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin sweep; sampled only in IDLE.
mode  input  2  internal function select; latched at start.
src_sel  input  1  0 = internal function, 1 = ext_f; latched at start.
ext_f  input  1  output of external circuit-under-test.
stim  output  N_IN  current input combination.
busy  output  1  high while sweeping.
done  output  1  one-cycle pulse at end of sweep.
tt  output  TT_W  recorded table; bit i = F(stim = i).
pass  output  1  see Optional Feature.
mismatch_cnt  output  N_IN+1  see Optional Feature.

Behaviour:
- Reset (async, any state): state=IDLE; stim=0, busy=0, done=0, tt=0, pass=0, mismatch_cnt=0; latched mode/src_sel=0.
- Internal function, with R = OR of stim[N_IN-2:0] and P = AND of stim[N_IN-2:0]: mode0 F = A & R; mode1 F = A | P; mode2 F = A ^ R; mode3 F = ~(A & R).
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - start=1 at edge E0 -> APPLY.
  - At E0: idx=0, stim=0, settle counter=0, tt cleared to 0, mode/src_sel latched, busy=1.
- APPLY:
  - Each vector holds stim for SETTLE+1 cycles.
  - On the edge ending the last of those cycles, tt[idx] is written from the selected source (internal F evaluated on the current stim, or ext_f).
  - On that same edge, if idx < TT_W-1: idx and stim increment and the settle counter clears.
  - If idx = TT_W-1: go to DONE; busy=0, done=1.
- DONE: lasts one cycle. done=0 on leaving; back to IDLE. stim returns to 0; tt holds until the next start.
- Timing: busy is high for exactly TT_W*(SETTLE+1) cycles after E0. done is high in the cycle after the last busy cycle.
  - N_IN=3, SETTLE=1: busy for 16 cycles, done in cycle 17.
- start while busy or in DONE: ignored, with no restart.
- mode, src_sel or ext_f changes mid-sweep: mode/src_sel use the latched values. ext_f is sampled only on write edges.
- Reset mid-sweep: immediate return to reset values; the partial tt is discarded.
- No wrap: idx never exceeds TT_W-1. The stim increment is N_IN bits wide and is not applied at the last vector.

Optional Feature:
Macro TT_CHECK_EN.
- Defined:
  - At each tt write, the internal golden F for the latched mode is compared with the recorded bit.
  - Each mismatch increments mismatch_cnt (N_IN+1 bits, cannot overflow). mismatch_cnt is cleared at start.
  - pass is set with done if mismatch_cnt = 0 (including the final sample) and src_sel=1. pass holds until the next start or reset.
  - With src_sel=0, pass is set whenever done is set and mismatch_cnt stays 0.
- Not defined: no compare logic; pass and mismatch_cnt are tied to 0. All other behaviour is identical.

Test Plan:
- N_IN=3, SETTLE=1, src_sel=0, mode0, start pulse -> busy 16 cycles, done one cycle at cycle 17, tt=8'hE0, stim steps 0..7, each held 2 cycles.
- Same setup, modes 1/2/3 back-to-back -> tt=8'hF8, 8'h1E, 8'h1F; tt cleared at each start.
- src_sel=1, ext_f driven as correct gate-level A&(B|C) of stim, mode0, TT_CHECK_EN -> tt=8'hE0, mismatch_cnt=0, pass=1 with done.
- src_sel=1, ext_f stuck at 1, mode0, TT_CHECK_EN -> tt=8'hFF, mismatch_cnt=5, pass=0.
- start re-pulsed at cycle 5, mode changed at cycle 6 -> no restart, result still for the original mode; rst asserted at cycle 9 -> all outputs 0 asynchronously, then a new sweep completes normally.
- SETTLE=0, N_IN=4, mode1 -> busy exactly 16 cycles, tt=16'hFF80; without TT_CHECK_EN, pass=0 and mismatch_cnt=0 throughout.
